// File: rtl/qtable_best_hop_scan_pkg.sv
// Shared constants, FSM encoding and packet codes for the best-hop scanner.
// Optional energy gate: define QTSCAN_MIN_ENERGY_EN.
package qtable_best_hop_scan_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int MEM_DEPTH  = 2048;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      SCAN   = 2'd2,
      FINISH = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      PKT_DATA = 3'b101
   } pkt_t;

   function automatic logic [WORD_WIDTH-1:0] clamp_count(
      input logic [WORD_WIDTH-1:0] cnt
   );
      logic [WORD_WIDTH-1:0] depth;
      depth = WORD_WIDTH'(MEM_DEPTH);
      return (cnt > depth) ? depth : cnt;
   endfunction

endpackage

// File: rtl/qtable_best_hop_scan_if.sv
// Request, bank read port and result bundle of the best-hop scanner.
// Carries minEnergy when QTSCAN_MIN_ENERGY_EN is defined.
interface qtable_best_hop_scan_if
   import qtable_best_hop_scan_pkg::*;
();

   logic                  en;
   logic [WORD_WIDTH-1:0] neighborCount;
   logic [WORD_WIDTH-1:0] rd_index;
   logic [WORD_WIDTH-1:0] mSourceID;
   logic [WORD_WIDTH-1:0] mClusterID;
   logic [WORD_WIDTH-1:0] mEnergyLeft;
   logic [WORD_WIDTH-1:0] mQValue;
   logic [WORD_WIDTH-1:0] bestID;
   logic [WORD_WIDTH-1:0] bestClusterID;
   logic [WORD_WIDTH-1:0] bestEnergy;
   logic [WORD_WIDTH-1:0] bestQValue;
   logic [WORD_WIDTH-1:0] bestIndex;
   logic                  valid;
   logic                  busy;
   logic                  done;
`ifdef QTSCAN_MIN_ENERGY_EN
   logic [WORD_WIDTH-1:0] minEnergy;
`endif

   modport master (
`ifdef QTSCAN_MIN_ENERGY_EN
      output minEnergy,
`endif
      output en, neighborCount,
      output mSourceID, mClusterID, mEnergyLeft, mQValue,
      input  rd_index,
      input  bestID, bestClusterID, bestEnergy, bestQValue, bestIndex,
      input  valid, busy, done
   );

   modport slave (
`ifdef QTSCAN_MIN_ENERGY_EN
      input  minEnergy,
`endif
      input  en, neighborCount,
      input  mSourceID, mClusterID, mEnergyLeft, mQValue,
      output rd_index,
      output bestID, bestClusterID, bestEnergy, bestQValue, bestIndex,
      output valid, busy, done
   );

endinterface

// File: rtl/qtable_hop_compare.sv
// "Candidate beats best" predicate on (Q, energy), with optional energy gate.
// Gate present when QTSCAN_MIN_ENERGY_EN is defined.
module qtable_hop_compare
   import qtable_best_hop_scan_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] cand_q,
   input  logic [WORD_WIDTH-1:0] cand_e,
   input  logic [WORD_WIDTH-1:0] best_q,
   input  logic [WORD_WIDTH-1:0] best_e,
   input  logic                  have_best,
`ifdef QTSCAN_MIN_ENERGY_EN
   input  logic [WORD_WIDTH-1:0] min_energy,
`endif
   output logic                  beats
);

   logic eligible;
   logic better;

`ifdef QTSCAN_MIN_ENERGY_EN
   assign eligible = (cand_e >= min_energy);
`else
   assign eligible = 1'b1;
`endif

   // Strict compares keep the earlier index on a full tie.
   assign better = (cand_q > best_q) ||
                   ((cand_q == best_q) && (cand_e > best_e));

   assign beats = eligible && (!have_best || better);

endmodule

// File: rtl/qtable_best_hop_scan.sv
// Sweeps the neighbour banks and keeps the highest-Q entry as next hop.
// Optional energy gate: define QTSCAN_MIN_ENERGY_EN.
module qtable_best_hop_scan
   import qtable_best_hop_scan_pkg::*;
(
   input  logic clk,
   input  logic nrst,
   qtable_best_hop_scan_if.slave bus
);

   localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

   state_t                state;
   logic [WORD_WIDTH-1:0] n;
   logic [WORD_WIDTH-1:0] last;
   logic [WORD_WIDTH-1:0] cmp_idx;
   logic                  beats;

   assign last = n - ONE;

   qtable_hop_compare u_cmp (
      .cand_q     (bus.mQValue),
      .cand_e     (bus.mEnergyLeft),
      .best_q     (bus.bestQValue),
      .best_e     (bus.bestEnergy),
      .have_best  (bus.valid),
`ifdef QTSCAN_MIN_ENERGY_EN
      .min_energy (bus.minEnergy),
`endif
      .beats      (beats)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state             <= IDLE;
         n                 <= '0;
         cmp_idx           <= '0;
         bus.rd_index      <= '0;
         bus.bestID        <= '0;
         bus.bestClusterID <= '0;
         bus.bestEnergy    <= '0;
         bus.bestQValue    <= '0;
         bus.bestIndex     <= '0;
         bus.valid         <= 1'b0;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.en) begin
                  n                 <= clamp_count(bus.neighborCount);
                  cmp_idx           <= '0;
                  bus.rd_index      <= '0;
                  bus.bestID        <= '0;
                  bus.bestClusterID <= '0;
                  bus.bestEnergy    <= '0;
                  bus.bestQValue    <= '0;
                  bus.bestIndex     <= '0;
                  bus.valid         <= 1'b0;
                  bus.busy          <= 1'b1;
                  state <= (bus.neighborCount == '0) ? FINISH : PRIME;
               end
            end
            PRIME: begin
               if (bus.rd_index < last) bus.rd_index <= bus.rd_index + ONE;
               cmp_idx <= bus.rd_index;
               state   <= SCAN;
            end
            SCAN: begin
               // m* now carries entry cmp_idx (one-cycle bank latency).
               if (bus.rd_index < last) bus.rd_index <= bus.rd_index + ONE;
               cmp_idx <= bus.rd_index;
               if (beats) begin
                  bus.bestID        <= bus.mSourceID;
                  bus.bestClusterID <= bus.mClusterID;
                  bus.bestEnergy    <= bus.mEnergyLeft;
                  bus.bestQValue    <= bus.mQValue;
                  bus.bestIndex     <= cmp_idx;
                  bus.valid         <= 1'b1;
               end
               if (cmp_idx == last) state <= FINISH;
            end
            FINISH: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qtable_best_hop_scan.sv
// Directed bench for qtable_best_hop_scan with a synchronous bank model.
// Energy-gate vectors run when QTSCAN_MIN_ENERGY_EN is defined.
module tb_qtable_best_hop_scan;
   import qtable_best_hop_scan_pkg::*;

   localparam int AW = $clog2(MEM_DEPTH);

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   lat;
   int   max_rd;
   int   seen;
   logic [WORD_WIDTH-1:0] rd_log[$];

   logic [WORD_WIDTH-1:0] b_id[MEM_DEPTH];
   logic [WORD_WIDTH-1:0] b_ch[MEM_DEPTH];
   logic [WORD_WIDTH-1:0] b_e [MEM_DEPTH];
   logic [WORD_WIDTH-1:0] b_q [MEM_DEPTH];

   always #5 clk = ~clk;

   qtable_best_hop_scan_if bus();

   qtable_best_hop_scan dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   // Neighbour banks: one-cycle synchronous read.
   always @(posedge clk) begin
      bus.mSourceID   <= b_id[bus.rd_index[AW-1:0]];
      bus.mClusterID  <= b_ch[bus.rd_index[AW-1:0]];
      bus.mEnergyLeft <= b_e [bus.rd_index[AW-1:0]];
      bus.mQValue     <= b_q [bus.rd_index[AW-1:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input int i, input logic [15:0] id,
                       input logic [15:0] ch, input logic [15:0] e,
                       input logic [15:0] q);
      b_id[i] = id;
      b_ch[i] = ch;
      b_e[i]  = e;
      b_q[i]  = q;
   endtask

   task automatic run_scan(input logic [WORD_WIDTH-1:0] cnt,
                           input int poke);
      @(negedge clk);
      bus.neighborCount = cnt;
      bus.en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.en = 1'b0;
      lat = -1;
      rd_log.delete();
      rd_log.push_back(bus.rd_index);
      max_rd = int'(bus.rd_index);
      for (int c = 1; c <= 3000; c++) begin
         if (c == poke) begin
            bus.en = 1'b1;
            bus.neighborCount = 16'd1;
         end
         @(posedge clk);
         @(negedge clk);
         bus.en = 1'b0;
         if (bus.done) begin
            lat = c;
            break;
         end
         rd_log.push_back(bus.rd_index);
         if (int'(bus.rd_index) > max_rd) max_rd = int'(bus.rd_index);
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) load(i, '0, '0, '0, '0);
      bus.en = 1'b0;
      bus.neighborCount = '0;
`ifdef QTSCAN_MIN_ENERGY_EN
      bus.minEnergy = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_index", bus.rd_index, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_bestID", bus.bestID, 0);
      nrst = 1'b1;

      // Single entry
      load(0, 16'd1, 16'd2, 16'h8000, 16'h3000);
      run_scan(16'd1, 0);
      chk("one_lat", lat, 3);
      chk("one_valid", bus.valid, 1);
      chk("one_id", bus.bestID, 1);
      chk("one_ch", bus.bestClusterID, 2);
      chk("one_e", bus.bestEnergy, 16'h8000);
      chk("one_q", bus.bestQValue, 16'h3000);
      chk("one_idx", bus.bestIndex, 0);
      chk("one_busy", bus.busy, 0);

      // Max search
      load(0, 16'd1, 16'd10, 16'h1000, 16'h1000);
      load(1, 16'd2, 16'd11, 16'h1000, 16'hB800);
      load(2, 16'd3, 16'd12, 16'h1000, 16'h3000);
      load(3, 16'd4, 16'd13, 16'h1000, 16'h0800);
      run_scan(16'd4, 0);
      chk("max_lat", lat, 6);
      chk("max_id", bus.bestID, 2);
      chk("max_ch", bus.bestClusterID, 11);
      chk("max_q", bus.bestQValue, 16'hB800);
      chk("max_idx", bus.bestIndex, 1);
      chk("max_rd0", rd_log[0], 0);
      chk("max_rd1", rd_log[1], 1);
      chk("max_rd2", rd_log[2], 2);
      chk("max_rd3", rd_log[3], 3);
      chk("max_rdmax", max_rd, 3);

      // en while busy is ignored
      run_scan(16'd4, 2);
      chk("poke_lat", lat, 6);
      chk("poke_id", bus.bestID, 2);
      chk("poke_idx", bus.bestIndex, 1);
      repeat (5) @(negedge clk);
      chk("hold_q", bus.bestQValue, 16'hB800);
      chk("hold_done", bus.done, 0);
      chk("hold_busy", bus.busy, 0);

      // Reset mid-scan
      @(negedge clk);
      bus.neighborCount = 16'd8;
      bus.en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", bus.busy, 1);
      nrst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_rd", bus.rd_index, 0);
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_valid", bus.valid, 0);
      chk("mrst_id", bus.bestID, 0);
      chk("mrst_q", bus.bestQValue, 0);
      chk("mrst_done", bus.done, 0);
      nrst = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("mrst_nodone", seen, 0);
      run_scan(16'd3, 0);
      chk("post_lat", lat, 5);
      chk("post_id", bus.bestID, 2);
      chk("post_idx", bus.bestIndex, 1);

      // Ties
      load(0, 16'd5, 16'd1, 16'h1800, 16'h3000);
      load(1, 16'd6, 16'd1, 16'h8000, 16'h3000);
      load(2, 16'd7, 16'd1, 16'h8000, 16'h3000);
      run_scan(16'd3, 0);
      chk("tie_lat", lat, 5);
      chk("tie_idx", bus.bestIndex, 1);
      chk("tie_id", bus.bestID, 6);

      // Empty table
      run_scan(16'd0, 0);
      chk("empty_lat", lat, 1);
      chk("empty_valid", bus.valid, 0);
      chk("empty_id", bus.bestID, 0);
      chk("empty_rd", rd_log[0], 0);

`ifdef QTSCAN_MIN_ENERGY_EN
      load(0, 16'd8, 16'd3, 16'h1800, 16'hB800);
      load(1, 16'd9, 16'd4, 16'h8000, 16'h3000);
      bus.minEnergy = 16'h4000;
      run_scan(16'd2, 0);
      chk("gate_lat", lat, 4);
      chk("gate_valid", bus.valid, 1);
      chk("gate_idx", bus.bestIndex, 1);
      chk("gate_id", bus.bestID, 9);
      bus.minEnergy = 16'hFFFF;
      run_scan(16'd2, 0);
      chk("gate_none_lat", lat, 4);
      chk("gate_none_valid", bus.valid, 0);
      chk("gate_none_id", bus.bestID, 0);
      chk("gate_none_q", bus.bestQValue, 0);
      bus.minEnergy = '0;
`endif

      // Count beyond bank depth clamps to MEM_DEPTH
      load(MEM_DEPTH - 1, 16'hABCD, 16'd1, 16'd1, 16'hFFFF);
      run_scan(16'hFFFF, 0);
      chk("clamp_lat", lat, MEM_DEPTH + 2);
      chk("clamp_idx", bus.bestIndex, MEM_DEPTH - 1);
      chk("clamp_id", bus.bestID, 16'hABCD);
      chk("clamp_rdmax", max_rd, MEM_DEPTH - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qtable_best_hop_scan.md
Name: qtable_best_hop_scan

Overview:
- Read-side companion to the Q-table update block. That block writes neighbour entries (ID, cluster ID, energy, Q-value) into the per-field neighbour memory banks at index `neighborCount`.
- This block sweeps those same banks from index 0 up to `neighborCount`-1 on request.
- It returns the neighbour with the highest Q-value as the next-hop choice for the routing/transmit path.
- It shares the memory banks' read port and their 1-cycle synchronous read latency.

Parameters:
- WORD_WIDTH, 16, width of every table field and of the index.
- MEM_DEPTH, 2048, number of entries per memory bank; upper bound on entries scanned.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- en  in  1  start pulse; sampled only in IDLE
- neighborCount  in  WORD_WIDTH  number of valid entries; latched at start
- rd_index  out  WORD_WIDTH  read address to all neighbour banks
- mSourceID  in  WORD_WIDTH  bank data_out, node ID at the previous cycle's rd_index
- mClusterID  in  WORD_WIDTH  bank data_out, cluster ID
- mEnergyLeft  in  WORD_WIDTH  bank data_out, energy (unsigned fixed-point)
- mQValue  in  WORD_WIDTH  bank data_out, Q-value (unsigned fixed-point)
- bestID, bestClusterID, bestEnergy, bestQValue  out  WORD_WIDTH each  winning entry
- bestIndex  out  WORD_WIDTH  table index of the winner
- valid  out  1  at least one eligible entry found in the last scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: scan complete, best* and valid are stable

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state goes to IDLE;
  - rd_index, all best* outputs, valid, busy and done go to 0;
  - reset mid-scan abandons the scan with no done pulse.
- FSM states: IDLE, PRIME, SCAN, FINISH.
- IDLE:
  - en=1 latches N = min(neighborCount, MEM_DEPTH).
  - The same edge clears best*, valid and the running maximum, drives rd_index to 0 and sets busy.
  - Next state is FINISH if N=0, otherwise PRIME.
- PRIME:
  - The bank is fetching entry 0.
  - rd_index increments to 1 when N>1, otherwise it holds.
  - Next state is SCAN.
- SCAN:
  - Each cycle the m* inputs hold entry k, where k = rd_index issued on the previous cycle.
  - Entry k is compared against the running best.
  - rd_index increments while it is < N-1.
  - After entry N-1 is compared, next state is FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, next state is IDLE.
- Latency:
  - done is high N+2 cycles after the en-sampling edge for N≥1;
  - done is high 1 cycle after it for N=0, with valid=0.
- Compare rule, as unsigned compares:
  - entry k replaces the best if Q_k > bestQ;
  - or if Q_k == bestQ and E_k > bestEnergy;
  - any other tie keeps the lower index.
  - The first eligible entry always loads and sets valid.
- en while busy is ignored. en held high across FINISH starts a new scan from IDLE on the following edge.
- neighborCount changing during a scan has no effect, because N is latched.
- best* outputs hold their values after done until the next start or reset.
- rd_index never exceeds N-1 and never exceeds MEM_DEPTH-1.

Optional Feature:
- Macro: QTSCAN_MIN_ENERGY_EN.
- Defined:
  - adds input port minEnergy [WORD_WIDTH-1:0];
  - entries with mEnergyLeft < minEnergy are ineligible, and are neither compared nor allowed to set valid;
  - if no entry is eligible, done pulses with valid=0 and best*=0.
- Undefined: no extra port, and every entry 0..N-1 is eligible.
- Timing and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - WORD_WIDTH and MEM_DEPTH constants;
  - the FSM state encoding (IDLE=2'd0, PRIME=2'd1, SCAN=2'd2, FINISH=2'd3);
  - the packet-type codes, e.g. DATA=3'b101, for the downstream consumer.
- One sub-module, qtable_hop_compare: combinational "candidate beats best" predicate over (Q, E) pairs, including the optional energy gate.
- FSM, index counter and result registers live in the top module.
- Bench instantiates the existing neighbour memory banks driven by rd_index.

Test Plan:
- Single entry: banks preloaded {ID=1, CH=2, E=16'h8000, Q=16'h3000}, neighborCount=1, en pulse. Required: done 3 cycles after the en edge, valid=1, bestID=1, bestQValue=16'h3000, bestIndex=0.
- Max search: Q={16'h1000, 16'hB800, 16'h3000, 16'h0800} for IDs 1..4, N=4. Required: bestID=2, bestQValue=16'hB800, done at cycle 6, rd_index sequence 0,1,2,3.
- Ties: idx0 {Q=16'h3000, E=16'h1800}, idx1 {Q=16'h3000, E=16'h8000}, idx2 {Q=16'h3000, E=16'h8000}. Required: bestIndex=1 (higher energy wins, then first-seen wins).
- Empty and restart: N=0 gives done 1 cycle after en with valid=0. en asserted during a running scan changes nothing.
- Reset mid-scan: N=8, drop nrst at cycle 4. Required: all outputs 0 next edge, no done pulse. A new en afterwards completes normally.
- With QTSCAN_MIN_ENERGY_EN, minEnergy=16'h4000, entries {Q=16'hB800, E=16'h1800} and {Q=16'h3000, E=16'h8000}. Required: bestIndex=1. With minEnergy=16'hFFFF: valid=0.
